// File: rtl/life_pkg.sv
// Shared types and cell-index mapping for the 4x4 Life
// array sequencer.
package life_pkg;

    localparam int CELL_W = 2;
    localparam int NCELLS = 16;
    localparam int IDX_W  = $clog2(NCELLS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOAD
    } state_t;

    typedef struct packed {
        logic [CELL_W-1:0] row;
        logic [CELL_W-1:0] col;
    } cell_t;

    // Cell i sits at row=i[3:2], col=i[1:0].
    function automatic cell_t idx2cell(input logic [IDX_W-1:0] idx);
        cell_t c;
        c.row = idx[2*CELL_W-1:CELL_W];
        c.col = idx[CELL_W-1:0];
        return c;
    endfunction

endpackage

// File: rtl/life_sequencer_if.sv
// Command, user-edit and array-port bundle between the
// sequencer and its controller.
interface life_sequencer_if;
    import life_pkg::*;

    logic              frame;
    logic              start;
    logic              stop;
    logic              step;
    logic              seed_load;
    logic [NCELLS-1:0] seed;
    logic              usr_req;
    logic [CELL_W-1:0] usr_row;
    logic [CELL_W-1:0] usr_col;
    logic              usr_val;
    logic              usr_ack;
    logic [CELL_W-1:0] arr_row;
    logic [CELL_W-1:0] arr_col;
    logic              arr_val;
    logic              arr_write_enb;
    logic              arr_run;
    logic              busy;
    logic              running;
    logic [15:0]       gen_count;

    modport master (
        output frame, start, stop, step, seed_load, seed,
        output usr_req, usr_row, usr_col, usr_val,
        input  usr_ack, arr_row, arr_col, arr_val,
        input  arr_write_enb, arr_run, busy, running, gen_count
    );

    modport slave (
        input  frame, start, stop, step, seed_load, seed,
        input  usr_req, usr_row, usr_col, usr_val,
        output usr_ack, arr_row, arr_col, arr_val,
        output arr_write_enb, arr_run, busy, running, gen_count
    );

endinterface

// File: rtl/life_frame_div.sv
// Frame divider: counts frame pulses, ticks on every DIV-th
// one and restarts from zero when cleared.
module life_frame_div #(
    parameter int DIV = 30,
    parameter int W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Run/stop/step sequencing and single write-port arbitration
// for the 4x4 Life cell array.
module life_sequencer
    import life_pkg::*;
#(
    parameter int FRAME_DIV = 30,
    parameter int DIV_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    life_sequencer_if.slave bus
);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [NCELLS-1:0] r_seed, w_seed_nxt;
    logic              r_run_pend, w_run_pend_nxt;
    logic              r_step_pend, w_step_pend_nxt;
    logic [15:0]       r_gen, w_gen_nxt;

    logic              r_arr_run, w_arr_run;
    logic              r_we, w_we;
    cell_t             r_cell, w_cell;
    logic              r_val, w_val;
    logic              r_ack, w_ack;
    logic              r_busy, w_busy;
    logic              r_running;

    logic              w_enter_load;
    logic              w_load_act;
    logic              w_stop_acc;
    logic              w_start_acc;
    logic              w_step_acc;
    logic              w_div_en;
    logic              w_tick;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [NCELLS-1:0] w_ld_seed;

    life_frame_div #(
        .DIV (FRAME_DIV),
        .W   (DIV_W)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_start_acc),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    always_comb begin
        w_enter_load = bus.seed_load && (r_state != ST_LOAD);
        w_load_act   = w_enter_load || (r_state == ST_LOAD);
        w_stop_acc   = (r_state == ST_RUN) && bus.stop
                       && !bus.seed_load;
        w_start_acc  = (r_state == ST_IDLE) && bus.start
                       && !bus.stop && !bus.seed_load;
        w_step_acc   = (r_state == ST_IDLE) && bus.step
                       && !bus.seed_load;
        w_div_en     = bus.frame && (r_state == ST_RUN)
                       && !w_stop_acc && !bus.seed_load;
        w_ld_idx     = w_enter_load ? '0 : r_idx;
        w_ld_seed    = w_enter_load ? bus.seed : r_seed;

        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_seed_nxt      = r_seed;
        w_run_pend_nxt  = r_run_pend;
        w_step_pend_nxt = r_step_pend;
        w_gen_nxt       = r_gen;
        w_arr_run       = 1'b0;
        w_we            = 1'b0;
        w_cell          = '0;
        w_val           = 1'b0;
        w_ack           = 1'b0;
        w_busy          = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_enter_load)     w_state_nxt = ST_LOAD;
                else if (w_start_acc) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_enter_load)     w_state_nxt = ST_LOAD;
                else if (w_stop_acc)  w_state_nxt = ST_IDLE;
            end
            ST_LOAD: begin
                if (r_idx == IDX_W'(NCELLS - 1))
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // One array operation per cycle: load, then run, then user.
        if (w_load_act) begin
            w_we   = 1'b1;
            w_cell = idx2cell(w_ld_idx);
            w_val  = w_ld_seed[w_ld_idx];
            w_busy = 1'b1;
        end else if (r_run_pend && !w_stop_acc) begin
            w_arr_run      = 1'b1;
            w_gen_nxt      = r_gen + 16'd1;
            w_run_pend_nxt = 1'b0;
        end else if (bus.usr_req && !r_ack) begin
            w_we       = 1'b1;
            w_ack      = 1'b1;
            w_cell.row = bus.usr_row;
            w_cell.col = bus.usr_col;
            w_val      = bus.usr_val;
        end

        if (w_enter_load) begin
            w_seed_nxt      = bus.seed;
            w_idx_nxt       = IDX_W'(1);
            w_gen_nxt       = '0;
            w_run_pend_nxt  = 1'b0;
            w_step_pend_nxt = 1'b0;
        end else if (r_state == ST_LOAD) begin
            w_idx_nxt = r_idx + IDX_W'(1);
        end else if (w_stop_acc) begin
            w_run_pend_nxt = 1'b0;
        end else begin
            if (w_tick)
                w_run_pend_nxt = 1'b1;
            if (bus.frame && r_step_pend) begin
                w_run_pend_nxt  = 1'b1;
                w_step_pend_nxt = 1'b0;
            end
            if (w_step_acc)
                w_step_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_seed      <= '0;
            r_run_pend  <= 1'b0;
            r_step_pend <= 1'b0;
            r_gen       <= '0;
            r_arr_run   <= 1'b0;
            r_we        <= 1'b0;
            r_cell      <= '0;
            r_val       <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_seed      <= w_seed_nxt;
            r_run_pend  <= w_run_pend_nxt;
            r_step_pend <= w_step_pend_nxt;
            r_gen       <= w_gen_nxt;
            r_arr_run   <= w_arr_run;
            r_we        <= w_we;
            r_cell      <= w_cell;
            r_val       <= w_val;
            r_ack       <= w_ack;
            r_busy      <= w_busy;
            r_running   <= (w_state_nxt == ST_RUN);
        end
    end

    assign bus.arr_run       = r_arr_run;
    assign bus.arr_write_enb = r_we;
    assign bus.arr_row       = r_cell.row;
    assign bus.arr_col       = r_cell.col;
    assign bus.arr_val       = r_val;
    assign bus.usr_ack       = r_ack;
    assign bus.busy          = r_busy;
    assign bus.running       = r_running;
    assign bus.gen_count     = r_gen;

endmodule
